// File: rtl/uart_pkg.sv
// Shared UART1 definitions: transmitter FSM states and serial line levels.
// The receiver imports the same line-level constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: o_bit_end marks the last clk of each serial bit.
// i_restart pins the count at zero so every frame starts phase-aligned.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_bit_end
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_restart || (r_cnt == LAST_CNT)) begin
      r_cnt <= {CW{1'b0}};
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_bit_end = (r_cnt == LAST_CNT);

endmodule

// File: rtl/uart_transmitter.sv
// UART1 transmitter: start bit, MSB-first data, STOP_BITS stop bits, with a
// one-entry holding buffer so frames can run back-to-back.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
  localparam logic [1:0]    LAST_STOP = 2'(STOP_BITS - 1);

  uart_state_e          r_state;
  uart_state_e          w_next;
  logic [DATA_BITS-1:0] r_buf;
  logic [DATA_BITS-1:0] r_shift;
  logic [IW-1:0]        r_idx;
  logic [1:0]           r_stop_cnt;
  logic                 r_buf_full;
  logic                 r_tx_ready;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_bit_end;
  logic                 w_restart;
  logic                 w_load;
  logic                 w_shift;
  logic                 w_tx;
  logic                 w_done;
  logic                 w_accept;

  assign w_accept = i_tx_valid && r_tx_ready;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_restart (w_restart),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_restart = 1'b0;
    case (r_state)
      IDLE: begin
        w_restart = 1'b1;
        if (r_buf_full) begin
          w_load = 1'b1;
          w_next = START;
        end else begin
          w_next = IDLE;
        end
      end
      START: begin
        if (w_bit_end) w_next = DATA;
        else           w_next = START;
      end
      DATA: begin
        if (w_bit_end && (r_idx == LAST_IDX)) w_next = STOP;
        else                                  w_next = DATA;
      end
      STOP: begin
        // A buffered byte chains straight into the next start bit.
        if (w_bit_end && (r_stop_cnt == LAST_STOP)) begin
          if (r_buf_full) begin
            w_load    = 1'b1;
            w_restart = 1'b1;
            w_next    = START;
          end else begin
            w_next = IDLE;
          end
        end else begin
          w_next = STOP;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_tx    = LINE_IDLE;
    w_done  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      IDLE:  w_tx = LINE_IDLE;
      START: w_tx = LINE_START;
      DATA: begin
        w_tx    = r_shift[DATA_BITS-1];
        w_shift = w_bit_end;
      end
      STOP: begin
        w_tx   = LINE_IDLE;
        w_done = w_bit_end && (r_stop_cnt == LAST_STOP);
      end
      default: w_tx = LINE_IDLE;
    endcase
  end

  // Holding buffer: a same-cycle accept wins over the load that empties it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_buf      <= {DATA_BITS{1'b0}};
      r_buf_full <= 1'b0;
      r_tx_ready <= 1'b1;
    end else if (w_accept) begin
      r_buf      <= i_tx_data;
      r_buf_full <= 1'b1;
      r_tx_ready <= 1'b0;
    end else if (w_load) begin
      r_buf_full <= 1'b0;
      r_tx_ready <= 1'b1;
    end else begin
      r_buf_full <= r_buf_full;
      r_tx_ready <= r_tx_ready;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shift    <= {DATA_BITS{1'b0}};
      r_idx      <= {IW{1'b0}};
      r_stop_cnt <= 2'd0;
    end else begin
      if (w_load) begin
        r_shift <= r_buf;
      end else if (w_shift) begin
        r_shift <= {r_shift[DATA_BITS-2:0], 1'b0};
      end else begin
        r_shift <= r_shift;
      end
      if (r_state == START) begin
        r_idx <= {IW{1'b0}};
      end else if (w_shift) begin
        r_idx <= r_idx + IW'(1);
      end else begin
        r_idx <= r_idx;
      end
      if (r_state != STOP) begin
        r_stop_cnt <= 2'd0;
      end else if (w_bit_end) begin
        r_stop_cnt <= r_stop_cnt + 2'd1;
      end else begin
        r_stop_cnt <= r_stop_cnt;
      end
    end
  end

  // Outputs lag the state by one clk so they carry no input-to-output path.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tx   <= LINE_IDLE;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_tx   <= w_tx;
      r_busy <= (r_state != IDLE);
      r_done <= w_done;
    end
  end

  assign o_tx_ready = r_tx_ready;
  assign o_tx       = r_tx;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: one instance at 1 clk/bit, one at
// 4 clk/bit with two stop bits, plus a one-sample-per-clk receiver model.
module tb_uart_transmitter;

  logic       clk;
  logic       rst_n;
  logic [7:0] data1, data4;
  logic       valid1, valid4;
  logic       ready1, ready4;
  logic       tx1, tx4;
  logic       busy1, busy4;
  logic       done1, done4;

  int n_tests = 0;
  int n_fail  = 0;

  logic       rx_en;
  int         rx_cnt;
  logic [7:0] rx_sh;
  logic [7:0] rx_q[$];

  uart_transmitter #(.CLKS_PER_BIT(1), .DATA_BITS(8), .STOP_BITS(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(data1), .i_tx_valid(valid1),
    .o_tx_ready(ready1), .o_tx(tx1), .o_busy(busy1), .o_done(done1)
  );

  uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(2)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(data4), .i_tx_valid(valid4),
    .o_tx_ready(ready4), .o_tx(tx4), .o_busy(busy4), .o_done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiver model: start on a low sample, shift 8 samples into the LSB,
  // and deliver the byte when the stop sample is high.
  always @(negedge clk) begin
    if (!rx_en) begin
      rx_cnt <= 0;
    end else if (rx_cnt == 0) begin
      if (tx1 == 1'b0) rx_cnt <= 1;
    end else if (rx_cnt <= 8) begin
      rx_sh  <= {rx_sh[6:0], tx1};
      rx_cnt <= rx_cnt + 1;
    end else begin
      if (tx1 == 1'b1) rx_q.push_back(rx_sh);
      rx_cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input bit sel, input string tag);
    chk({tag, "_tx"},   sel ? tx4 : tx1,     1'b1);
    chk({tag, "_busy"}, sel ? busy4 : busy1, 1'b0);
    chk({tag, "_done"}, sel ? done4 : done1, 1'b0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic offer(input bit sel, input logic [7:0] d);
    int n = 0;
    if (sel) begin data4 = d; valid4 = 1'b1; end
    else     begin data1 = d; valid1 = 1'b1; end
    while (((sel ? ready4 : ready1) == 1'b0) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    chk("offer_ready", sel ? ready4 : ready1, 1'b1);
    @(negedge clk);
    valid1 = 1'b0;
    valid4 = 1'b0;
  endtask

  // Checks one frame, MSB of fb[nb-1:0] first, each bit held cpb samples.
  task automatic stream(input bit sel, input string tag, input logic [10:0] fb,
                        input int nb, input int cpb);
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < cpb; c++) begin
        chk({tag, "_tx"},   sel ? tx4 : tx1,     fb[nb-1-b]);
        chk({tag, "_busy"}, sel ? busy4 : busy1, 1'b1);
        chk({tag, "_done"}, sel ? done4 : done1, (b == nb-1) && (c == cpb-1));
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    data1  = 8'h00; data4  = 8'h00;
    valid1 = 1'b0;  valid4 = 1'b0;
    rx_en  = 1'b0;

    // 1. reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_chk(1'b0, "rst1");
      chk("rst1_ready", ready1, 1'b1);
      idle_chk(1'b1, "rst4");
      chk("rst4_ready", ready4, 1'b1);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // 2. single byte 0xA5
    offer(1'b0, 8'hA5);
    @(negedge clk);
    chk("a5_lat_tx", tx1, 1'b1);
    chk("a5_lat_busy", busy1, 1'b0);
    @(negedge clk);
    stream(1'b0, "a5", {1'b0, 1'b0, 8'hA5, 1'b1}, 10, 1);
    idle_chk(1'b0, "a5_end");
    @(negedge clk);

    // 3. back-to-back 0x00 then 0xFF
    data1 = 8'h00; valid1 = 1'b1;
    @(negedge clk);
    chk("b2b_full", ready1, 1'b0);
    data1 = 8'hFF;
    @(negedge clk);
    chk("b2b_ready", ready1, 1'b1);
    @(negedge clk);
    valid1 = 1'b0;
    stream(1'b0, "b2b0", {1'b0, 1'b0, 8'h00, 1'b1}, 10, 1);
    stream(1'b0, "b2b1", {1'b0, 1'b0, 8'hFF, 1'b1}, 10, 1);
    idle_chk(1'b0, "b2b_end");
    chk("b2b_end_ready", ready1, 1'b1);

    // 4. loopback into the receiver model
    rx_q.delete();
    rx_en = 1'b1;
    @(negedge clk);
    offer(1'b0, 8'h3C);
    offer(1'b0, 8'h81);
    offer(1'b0, 8'h7E);
    for (int i = 0; (i < 80) && (rx_q.size() < 3); i++) @(negedge clk);
    chk("loop_count", rx_q.size(), 3);
    if (rx_q.size() > 0) chk("loop_3c", rx_q[0], 8'h3C);
    if (rx_q.size() > 1) chk("loop_81", rx_q[1], 8'h81);
    if (rx_q.size() > 2) chk("loop_7e", rx_q[2], 8'h7E);
    rx_en = 1'b0;
    @(negedge clk);

    // 5. CLKS_PER_BIT=4, STOP_BITS=2, byte 0x01
    offer(1'b1, 8'h01);
    chk("c4_notready", ready4, 1'b0);
    @(negedge clk);
    chk("c4_ready_after_load", ready4, 1'b1);
    chk("c4_lat_tx", tx4, 1'b1);
    @(negedge clk);
    stream(1'b1, "c4", {1'b0, 8'h01, 2'b11}, 11, 4);
    idle_chk(1'b1, "c4_end");

    // 6. reset during d[3] of 0x55 with 0xAA buffered
    @(negedge clk);
    offer(1'b0, 8'h55);
    data1 = 8'hAA; valid1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    valid1 = 1'b0;
    chk("rst_mid_start", tx1, 1'b0);
    repeat (5) @(negedge clk);
    chk("rst_mid_d3", tx1, 1'b0);
    chk("rst_mid_buffered", ready1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    idle_chk(1'b0, "rst_mid");
    chk("rst_mid_ready", ready1, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      idle_chk(1'b0, "post_rst");
    end
    chk("post_rst_ready", ready1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
